tick_sched: RTL

TICK_SCHED -- requirements
Module: tick_sched

---
 rtl/tick_sched.sv | 116 +++++++++++
 1 files changed

// File: rtl/tick_sched.sv
// Shared 1 Hz countdown engine: round-robin arbitration among N_REQ requesters,
// counts the winner's duration down on tick_in and pulses done on expiry.
module tick_sched #(
  parameter int N_REQ = 4,
  parameter int DUR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_in,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] req_dur,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [N_REQ-1:0]       done,
  output logic [DUR_W-1:0]       remaining
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state, state_nxt;
  logic [IW-1:0]               ptr, ptr_nxt, owner, owner_nxt, sel;
  logic                        found;
  logic [N_REQ-1:0]            grant_nxt, done_nxt;
  logic                        busy_nxt;
  logic [DUR_W-1:0]            rem_nxt;
  logic [N_REQ-1:0][DUR_W-1:0] dur;

  for (genvar g = 0; g < N_REQ; g++) begin : g_dur
    assign dur[g] = req_dur[g*DUR_W +: DUR_W];
  end

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin : arb
    int idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    grant_nxt = '0;
    done_nxt  = '0;
    busy_nxt  = 1'b0;
    rem_nxt   = '0;
    unique case (state)
      IDLE: if (found) begin
        owner_nxt = sel;
        if (dur[sel] != '0) begin
          state_nxt = RUN;
          grant_nxt = N_REQ'(1) << sel;
          busy_nxt  = 1'b1;
          rem_nxt   = dur[sel];
        end else begin
          state_nxt = DONE;
          done_nxt  = N_REQ'(1) << sel;
          ptr_nxt   = inc(sel);
        end
      end
      RUN: begin
        // Abort is checked first so it beats a coincident final tick.
        if (!req[owner]) begin
          state_nxt = IDLE;
          ptr_nxt   = inc(owner);
        end else if (tick_in && remaining == DUR_W'(1)) begin
          state_nxt = DONE;
          done_nxt  = N_REQ'(1) << owner;
          ptr_nxt   = inc(owner);
        end else begin
          grant_nxt = grant;
          busy_nxt  = 1'b1;
          rem_nxt   = tick_in ? remaining - 1'b1 : remaining;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      remaining <= rem_nxt;
    end
  end

endmodule
